playfield_vscroll_sequencer: RTL and testbench

- Schedules when the playfield vertical scroll counters are loaded.
- Two requesters share the single scroll load path:
  - CPU frame writes, applied at the start of vertical blank.
  - One raster split request, applied at a programmed scanline.
- Drives the 9-bit load value and the load strobe into the playfield vertical scroll counter chain, and keeps its own scanline count to time splits.

---
 rtl/playfield_vscroll_sequencer.sv | 147 ++++++++++++++
 tb/tb_playfield_vscroll_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_vscroll_sequencer.sv
// Playfield vertical scroll load sequencer.
// Arbitrates CPU frame writes (applied at vblank rise) and one raster split
// (applied at a programmed scanline) onto the single scroll counter load path.
// Each load holds vscrld high for LOAD_LEN clocks, then idles for one HOLD
// clock. An event arriving while busy waits in a one-deep slot where the
// latest value wins.
module playfield_vscroll_sequencer #(
   parameter int LOAD_LEN = 2,
   parameter int LINE_W   = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vblank,
   input  logic              hsync_start,
   input  logic              cpu_vscrl_we,
   input  logic [LINE_W-1:0] cpu_vscrl_d,
   input  logic              split_we,
   input  logic [LINE_W-1:0] split_line,
   input  logic [LINE_W-1:0] split_d,
   output logic              vscrld,
   output logic [LINE_W-1:0] vbd,
   output logic [LINE_W-1:0] line_cnt,
   output logic              cpu_pending,
   output logic              split_pending,
   output logic              split_done,
   output logic              split_miss
);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   localparam logic [LINE_W-1:0] LINE_MAX = '1;
   localparam logic [3:0]        LEN      = 4'(LOAD_LEN);

   state_t            state;
   logic              vb_q;
   logic [LINE_W-1:0] shadow;
   logic [LINE_W-1:0] sl_q;
   logic [LINE_W-1:0] sd_q;
   logic [3:0]        ld_cnt;
   logic              def_vld;
   logic [LINE_W-1:0] def_val;

   logic              frame_evt;
   logic              frame_ld;
   logic              split_ev;
   logic              evt;
   logic [LINE_W-1:0] cmp_line;
   logic [LINE_W-1:0] evt_val;

   // Event decode; a write landing on its own event cycle supplies the value.
   always_comb begin
      frame_evt = vblank & ~vb_q;
      frame_ld  = frame_evt & (cpu_pending | cpu_vscrl_we);
      cmp_line  = split_we ? split_line : sl_q;
      split_ev  = hsync_start & ~vblank & (split_pending | split_we) &
                  (line_cnt == cmp_line);
      evt       = frame_ld | split_ev;
      evt_val   = '0;
      if (frame_ld)
         evt_val = cpu_vscrl_we ? cpu_vscrl_d : shadow;
      else if (split_ev)
         evt_val = split_we ? split_d : sd_q;
   end

   // Request bookkeeping: vblank edge, scanline count, shadow and split regs.
   always_ff @(posedge clk) begin
      if (rst) begin
         vb_q          <= 1'b0;
         line_cnt      <= '0;
         shadow        <= '0;
         cpu_pending   <= 1'b0;
         sl_q          <= '0;
         sd_q          <= '0;
         split_pending <= 1'b0;
         split_done    <= 1'b0;
         split_miss    <= 1'b0;
      end else begin
         vb_q       <= vblank;
         split_done <= split_ev;
         // A split written on the frame cycle re-arms rather than expiring.
         split_miss <= frame_evt & split_pending & ~split_we;

         if (frame_evt)
            line_cnt <= '0;
         else if (hsync_start && !vblank && line_cnt != LINE_MAX)
            line_cnt <= line_cnt + 1'b1;

         if (cpu_vscrl_we)
            shadow <= cpu_vscrl_d;
         cpu_pending <= frame_evt ? 1'b0 : (cpu_pending | cpu_vscrl_we);

         if (split_we) begin
            sl_q <= split_line;
            sd_q <= split_d;
         end
         if (split_ev)
            split_pending <= 1'b0;
         else if (split_we)
            split_pending <= 1'b1;
         else if (frame_evt)
            split_pending <= 1'b0;
      end
   end

   // Load FSM: IDLE -> LOAD (LOAD_LEN clocks) -> HOLD (1 clock) -> IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         vscrld  <= 1'b0;
         vbd     <= '0;
         ld_cnt  <= '0;
         def_vld <= 1'b0;
         def_val <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (evt || def_vld) begin
                  vbd     <= evt ? evt_val : def_val;
                  vscrld  <= 1'b1;
                  ld_cnt  <= LEN;
                  def_vld <= 1'b0;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               if (ld_cnt == 4'd1) begin
                  vscrld <= 1'b0;
                  state  <= HOLD;
               end else begin
                  ld_cnt <= ld_cnt - 4'd1;
               end
            end
            HOLD: state <= IDLE;
            default: begin
               vscrld <= 1'b0;
               state  <= IDLE;
            end
         endcase
         // Busy: park the event, overwriting anything already parked.
         if (evt && state != IDLE) begin
            def_vld <= 1'b1;
            def_val <= evt_val;
         end
      end
   end

endmodule

// File: tb/tb_playfield_vscroll_sequencer.sv
// Bench for playfield_vscroll_sequencer: three instances (LOAD_LEN 2, 1, 15)
// share one stimulus; expectations are hand-derived per load length.
module tb_playfield_vscroll_sequencer;

   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst, vblank, hsync_start, cpu_vscrl_we, split_we;
   logic [8:0] cpu_vscrl_d, split_line, split_d;

   logic       vscrld_o [N];
   logic [8:0] vbd_o    [N];
   logic [8:0] line_o   [N];
   logic       cp_o     [N];
   logic       sp_o     [N];
   logic       done_o   [N];
   logic       miss_o   [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic int len_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      playfield_vscroll_sequencer #(
         .LOAD_LEN((g == 0) ? 2 : ((g == 1) ? 1 : 15)),
         .LINE_W  (9)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .vblank       (vblank),
         .hsync_start  (hsync_start),
         .cpu_vscrl_we (cpu_vscrl_we),
         .cpu_vscrl_d  (cpu_vscrl_d),
         .split_we     (split_we),
         .split_line   (split_line),
         .split_d      (split_d),
         .vscrld       (vscrld_o[g]),
         .vbd          (vbd_o[g]),
         .line_cnt     (line_o[g]),
         .cpu_pending  (cp_o[g]),
         .split_pending(sp_o[g]),
         .split_done   (done_o[g]),
         .split_miss   (miss_o[g])
      );
   end

   typedef struct {
      logic       rst, vb, hs, cwe;
      logic [8:0] cd;
      logic       swe;
      logic [8:0] sl, sd;
      int         ld_off;   // 0: load strobe low; n: high iff n <= LOAD_LEN
      logic [8:0] e_vbd, e_line;
      logic       e_cp, e_sp, e_done, e_miss;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input int d, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d LOAD_LEN=%0d got %0h want %0h", nm, d, len_of(d), act, exp);
      end
   endtask

   task automatic drv(input logic r, input logic vb, input logic hs, input logic cwe,
                      input logic [8:0] cd, input logic swe, input logic [8:0] sl,
                      input logic [8:0] sd);
      rst = r; vblank = vb; hsync_start = hs; cpu_vscrl_we = cwe; cpu_vscrl_d = cd;
      split_we = swe; split_line = sl; split_d = sd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic vb, input int n);
      drv(0, vb, 0, 0, 9'h0, 0, 9'h0, 9'h0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_ld(input string nm, input int off, input logic [8:0] v);
      for (int d = 0; d < N; d++) begin
         chk({nm, "_vscrld"}, d, vscrld_o[d], (off >= 1 && off <= len_of(d)) ? 1 : 0);
         chk({nm, "_vbd"}, d, vbd_o[d], v);
      end
   endtask

   initial begin
      int   off;
      int   ndone;
      logic exp_ld;
      drv(1, 1, 0, 0, 9'h0, 0, 9'h0, 9'h0);

      //            rst vb hs cwe cd      swe sl     sd     off vbd     line    cp sp dn ms
      tbl[0] = '{1'b1,1'b1,1'b0,1'b0,9'h000,1'b0,9'h000,9'h000,0,9'h000,9'd0,1'b0,1'b0,1'b0,1'b0};
      tbl[1] = '{1'b0,1'b1,1'b0,1'b0,9'h000,1'b0,9'h000,9'h000,0,9'h000,9'd0,1'b0,1'b0,1'b0,1'b0};
      tbl[2] = '{1'b0,1'b1,1'b1,1'b0,9'h000,1'b0,9'h000,9'h000,0,9'h000,9'd0,1'b0,1'b0,1'b0,1'b0};
      tbl[3] = '{1'b0,1'b0,1'b1,1'b0,9'h000,1'b0,9'h000,9'h000,0,9'h000,9'd1,1'b0,1'b0,1'b0,1'b0};
      tbl[4] = '{1'b0,1'b0,1'b0,1'b1,9'h0A5,1'b0,9'h000,9'h000,0,9'h000,9'd1,1'b1,1'b0,1'b0,1'b0};
      tbl[5] = '{1'b0,1'b0,1'b1,1'b0,9'h000,1'b0,9'h000,9'h000,0,9'h000,9'd2,1'b1,1'b0,1'b0,1'b0};
      tbl[6] = '{1'b0,1'b1,1'b0,1'b0,9'h000,1'b0,9'h000,9'h000,1,9'h0A5,9'd0,1'b0,1'b0,1'b0,1'b0};
      tbl[7] = '{1'b0,1'b1,1'b0,1'b0,9'h000,1'b0,9'h000,9'h000,2,9'h0A5,9'd0,1'b0,1'b0,1'b0,1'b0};
      tbl[8] = '{1'b0,1'b1,1'b0,1'b1,9'h033,1'b0,9'h000,9'h000,3,9'h0A5,9'd0,1'b1,1'b0,1'b0,1'b0};
      tbl[9] = '{1'b0,1'b1,1'b0,1'b0,9'h000,1'b0,9'h000,9'h000,4,9'h0A5,9'd0,1'b1,1'b0,1'b0,1'b0};

      // Reset, idle in vblank, CPU write then frame load.
      for (int i = 0; i < 10; i++) begin
         drv(tbl[i].rst, tbl[i].vb, tbl[i].hs, tbl[i].cwe, tbl[i].cd, tbl[i].swe,
             tbl[i].sl, tbl[i].sd);
         tick();
         for (int d = 0; d < N; d++) begin
            exp_ld = (tbl[i].ld_off >= 1 && tbl[i].ld_off <= len_of(d));
            chk($sformatf("vec%0d_vscrld", i), d, vscrld_o[d], exp_ld);
            chk($sformatf("vec%0d_vbd", i), d, vbd_o[d], tbl[i].e_vbd);
            chk($sformatf("vec%0d_line", i), d, line_o[d], tbl[i].e_line);
            chk($sformatf("vec%0d_cp", i), d, cp_o[d], tbl[i].e_cp);
            chk($sformatf("vec%0d_sp", i), d, sp_o[d], tbl[i].e_sp);
            chk($sformatf("vec%0d_done", i), d, done_o[d], tbl[i].e_done);
            chk($sformatf("vec%0d_miss", i), d, miss_o[d], tbl[i].e_miss);
         end
      end
      idle(1, 20);
      chk_ld("postcpu", 0, 9'h0A5);

      // Split at line 40 with value 0x120 across 64 scanlines.
      drv(0, 0, 0, 0, 9'h0, 1, 9'd40, 9'h120);
      tick();
      for (int d = 0; d < N; d++) chk("arm40_sp", d, sp_o[d], 1);
      off = 0;
      ndone = 0;
      for (int ln = 0; ln < 64; ln++) begin
         for (int c = 0; c < 4; c++) begin
            drv(0, 0, (c == 0), 0, 9'h0, 0, 9'h0, 9'h0);
            tick();
            if (off > 0) off++;
            if (c == 0 && ln == 40) off = 1;
            if (done_o[0]) ndone++;
            for (int d = 0; d < N; d++) begin
               chk("s40_vscrld", d, vscrld_o[d], (off >= 1 && off <= len_of(d)) ? 1 : 0);
               chk("s40_vbd", d, vbd_o[d], (off > 0) ? 9'h120 : 9'h0A5);
               chk("s40_done", d, done_o[d], (off == 1) ? 1 : 0);
            end
         end
      end
      for (int d = 0; d < N; d++) begin
         chk("s40_line", d, line_o[d], 64);
         chk("s40_sp", d, sp_o[d], 0);
      end
      chk("s40_done_count", 0, ndone, 1);

      // Split at line 300 never reached; the next frame expires it.
      drv(0, 0, 0, 0, 9'h0, 1, 9'd300, 9'h100);
      tick();
      for (int ln = 0; ln < 200; ln++) begin
         drv(0, 0, 1, 0, 9'h0, 0, 9'h0, 9'h0);
         tick();
         for (int d = 0; d < N; d++) chk("s300_done", d, done_o[d], 0);
         idle(0, 1);
      end
      for (int d = 0; d < N; d++) begin
         chk("s300_line", d, line_o[d], 264);
         chk("s300_sp", d, sp_o[d], 1);
      end
      drv(0, 1, 0, 0, 9'h0, 0, 9'h0, 9'h0);
      tick();
      for (int d = 0; d < N; d++) begin
         chk("s300_miss", d, miss_o[d], 1);
         chk("s300_sp_clr", d, sp_o[d], 0);
         chk("s300_cp_clr", d, cp_o[d], 0);
      end
      chk_ld("s300_frame", 1, 9'h033);
      tick();
      for (int d = 0; d < N; d++) chk("s300_miss_pulse", d, miss_o[d], 0);
      idle(1, 20);
      chk_ld("s300_after", 0, 9'h033);

      // Line counter saturates at 511.
      for (int ln = 0; ln < 520; ln++) begin
         drv(0, 0, 1, 0, 9'h0, 0, 9'h0, 9'h0);
         tick();
      end
      for (int d = 0; d < N; d++) chk("sat_line", d, line_o[d], 511);
      idle(1, 2);
      for (int d = 0; d < N; d++) chk("sat_clear", d, line_o[d], 0);

      // Split at line 5, CPU write at line 5, then two more events while busy.
      idle(0, 1);
      drv(0, 0, 0, 0, 9'h0, 1, 9'd5, 9'h055);
      tick();
      for (int ln = 0; ln < 5; ln++) begin
         drv(0, 0, 1, 0, 9'h0, 0, 9'h0, 9'h0);
         tick();
      end
      drv(0, 0, 0, 1, 9'h1AB, 0, 9'h0, 9'h0);
      tick();
      for (int d = 0; d < N; d++) chk("def_cp", d, cp_o[d], 1);
      drv(0, 0, 1, 0, 9'h0, 0, 9'h0, 9'h0);
      tick();
      for (int k = 1; k <= 36; k++) begin
         for (int d = 0; d < N; d++) begin
            int l;
            l = len_of(d);
            chk($sformatf("def_k%0d_vscrld", k), d, vscrld_o[d],
                ((k <= l) || (k >= l + 3 && k <= 2 * l + 2)) ? 1 : 0);
            chk($sformatf("def_k%0d_vbd", k), d, vbd_o[d], (k <= l + 2) ? 9'h055 : 9'h0CC);
            if (k <= 4)
               chk($sformatf("def_k%0d_done", k), d, done_o[d], (k == 1 || k == 3) ? 1 : 0);
         end
         if (k == 1)      drv(0, 1, 0, 0, 9'h0, 0, 9'h0, 9'h0);
         else if (k == 2) drv(0, 0, 1, 0, 9'h0, 1, 9'd0, 9'h0CC);
         else             drv(0, 0, 0, 0, 9'h0, 0, 9'h0, 9'h0);
         tick();
         if (k == 2)
            for (int d = 0; d < N; d++) chk("def_cp_clr", d, cp_o[d], 0);
      end

      // Reset in the middle of a load.
      idle(1, 1);
      idle(0, 1);
      drv(0, 0, 0, 1, 9'h077, 0, 9'h0, 9'h0);
      tick();
      drv(0, 0, 1, 0, 9'h0, 1, 9'd0, 9'h099);
      tick();
      chk_ld("rst_pre", 1, 9'h099);
      for (int d = 0; d < N; d++) chk("rst_pre_cp", d, cp_o[d], 1);
      drv(1, 0, 0, 0, 9'h0, 0, 9'h0, 9'h0);
      tick();
      chk_ld("rst_abort", 0, 9'h000);
      for (int d = 0; d < N; d++) begin
         chk("rst_line", d, line_o[d], 0);
         chk("rst_cp", d, cp_o[d], 0);
         chk("rst_sp", d, sp_o[d], 0);
         chk("rst_done", d, done_o[d], 0);
         chk("rst_miss", d, miss_o[d], 0);
      end
      idle(0, 2);
      chk_ld("rst_after", 0, 9'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
